// File: rtl/morse_pkg.sv
// morse_pkg: shared state type and default timing constants for the Morse key front end
package morse_pkg;
  typedef enum logic [1:0] {IDLE, PRESS, GAP} key_state_e;
  localparam int MORSE_DASH_UNITS = 2;
  localparam int MORSE_CHAR_GAP = 3;
  localparam int MORSE_WORD_GAP = 7;
endpackage

// File: rtl/morse_debounce.sv
// morse_debounce: 2-flop synchroniser plus optional debounce filter for the raw key line
// Ports: clk, rst (async active-low), i_key (raw async key),
//        o_level (clean level), o_rise / o_fall (one-cycle pulses in the cycle o_level changes).
// MORSE_KEY_DEBOUNCE_EN: when defined, o_level only follows the synchronised key after it has
// been stable for DEBOUNCE_CYCLES cycles; otherwise o_level is the synchroniser output.
module morse_debounce
  import morse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  logic r_s1, r_s2, r_prev;
  logic w_level;
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_key;
      r_s2 <= r_s1;
    end
`ifdef MORSE_KEY_DEBOUNCE_EN
  localparam int CNT_W = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [CNT_W-1:0] r_cnt;
  logic r_level;
  // Count consecutive cycles the synchronised key disagrees with the held level;
  // any agreement restarts the count, so short glitches never reach CNT_LAST.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_cnt <= '0;
      r_level <= 1'b0;
    end else if (r_s2 == r_level) r_cnt <= '0;
    else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
      r_level <= r_s2;
    end else r_cnt <= r_cnt + 1'b1;
  assign w_level = r_level;
`else
  assign w_level = r_s2;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_prev <= 1'b0;
    else r_prev <= w_level;
  assign o_level = w_level;
  assign o_rise = w_level & ~r_prev;
  assign o_fall = ~w_level & r_prev;
endmodule

// File: rtl/morse_key_classifier.sv
// morse_key_classifier: times debounced key presses/releases in Morse units and strobes symbols
// Ports: clk, rst (async active-low), key_in (raw async key, 1 = pressed),
//        dot_inp / dash_inp / char_space_inp / word_space_inp (one-cycle, mutually exclusive strobes),
//        key_level (debounced key level).
// MORSE_KEY_DEBOUNCE_EN: enables the debounce filter in morse_debounce.
module morse_key_classifier
  import morse_pkg::*;
#(
  parameter int CLK_PER_UNIT = 1000,
  parameter int DASH_UNITS = MORSE_DASH_UNITS,
  parameter int CHAR_GAP = MORSE_CHAR_GAP,
  parameter int WORD_GAP = MORSE_WORD_GAP,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic dot_inp,
  output logic dash_inp,
  output logic char_space_inp,
  output logic word_space_inp,
  output logic key_level
);
  localparam int CYC_W = $clog2(CLK_PER_UNIT);
  localparam int UNIT_W = $clog2(WORD_GAP + 1);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLK_PER_UNIT - 1);
  localparam logic [UNIT_W-1:0] U_DASH = UNIT_W'(DASH_UNITS);
  localparam logic [UNIT_W-1:0] U_CHAR = UNIT_W'(CHAR_GAP);
  localparam logic [UNIT_W-1:0] U_WORD = UNIT_W'(WORD_GAP);
  if (CLK_PER_UNIT < 8 || WORD_GAP <= CHAR_GAP) begin : g_bad_params
    $error("need CLK_PER_UNIT >= 8 and WORD_GAP > CHAR_GAP");
  end
  key_state_e r_state, w_next;
  logic [CYC_W-1:0] r_cyc;
  logic [UNIT_W-1:0] r_units, w_units_nx;
  logic r_char_sent, r_dot, r_dash, r_char, r_word;
  logic w_level, w_rise, w_fall, w_tick;
  logic w_dot, w_dash, w_char, w_word;
  morse_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk(clk),
    .rst(rst),
    .i_key(key_in),
    .o_level(w_level),
    .o_rise(w_rise),
    .o_fall(w_fall)
  );
  // Unit count as it will be after this edge; strobes key off it so they land exactly
  // on the N*CLK_PER_UNIT boundary rather than one cycle later.
  assign w_tick = r_cyc == CYC_LAST;
  assign w_units_nx = (w_tick && r_units != U_WORD) ? r_units + 1'b1 : r_units;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = (r_state == IDLE && w_rise) ? PRESS :
             (r_state == PRESS && w_fall) ? GAP :
             (r_state == GAP && w_rise) ? PRESS :
             w_word ? IDLE : r_state;
  end
  // A press edge in GAP wins over any gap strobe due in the same cycle.
  always_comb begin
    w_dot = r_state == PRESS && w_fall && w_units_nx < U_DASH;
    w_dash = r_state == PRESS && w_fall && w_units_nx >= U_DASH;
    w_char = r_state == GAP && !w_rise && !r_char_sent && w_tick && w_units_nx == U_CHAR;
    w_word = r_state == GAP && !w_rise && w_tick && w_units_nx == U_WORD;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_cyc <= '0;
      r_units <= '0;
      r_char_sent <= 1'b0;
    end else if (w_next != r_state) begin
      r_cyc <= '0;
      r_units <= '0;
      r_char_sent <= 1'b0;
    end else if (r_state != IDLE) begin
      r_cyc <= w_tick ? '0 : r_cyc + 1'b1;
      r_units <= w_units_nx;
      r_char_sent <= r_char_sent | w_char;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_dot <= 1'b0;
      r_dash <= 1'b0;
      r_char <= 1'b0;
      r_word <= 1'b0;
    end else begin
      r_dot <= w_dot;
      r_dash <= w_dash;
      r_char <= w_char;
      r_word <= w_word;
    end
  assign dot_inp = r_dot;
  assign dash_inp = r_dash;
  assign char_space_inp = r_char;
  assign word_space_inp = r_word;
  assign key_level = w_level;
endmodule

// File: tb/tb_morse_key_classifier.sv
// tb_morse_key_classifier: directed and random key timing checked against a timeline model
module tb_morse_key_classifier;
  localparam int CPU = 10, D = 4, DASH = 2, CG = 3, WG = 7, MAXC = 16384;
  logic clk = 1'b0, rst = 1'b0, key_in = 1'b0;
  logic dot_inp, dash_inp, char_space_inp, word_space_inp, key_level;
  int checks = 0, failures = 0;
  int cyc = 0, t_r = 0, last_strobe = -1000;
  int n_dot, n_dash, n_char, n_word, n_hi, c_dot, c_char, c_word;
  logic [31:0] hist = '0;
  logic lvl_m = 1'b0;
  logic [3:0] exp_s [MAXC];
  morse_key_classifier #(
    .CLK_PER_UNIT(CPU), .DASH_UNITS(DASH), .CHAR_GAP(CG), .WORD_GAP(WG), .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in),
    .dot_inp(dot_inp), .dash_inp(dash_inp), .char_space_inp(char_space_inp),
    .word_space_inp(word_space_inp), .key_level(key_level)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
    end
  endtask
  task automatic clr_stats();
    n_dot = 0; n_dash = 0; n_char = 0; n_word = 0; n_hi = 0;
    c_dot = -1; c_char = -1; c_word = -1;
  endtask
  // One clock: sample key at the edge, advance the timeline model, compare DUT outputs.
  task automatic step();
    logic nl, all_eq;
    logic [3:0] obs;
    int h;
    @(posedge clk);
    cyc++;
    hist = {hist[30:0], rst ? key_in : 1'b0};
    #1;
    if (!rst) begin
      hist = '0;
      lvl_m = 1'b0;
      for (int e = cyc; e <= cyc + WG * CPU + 2; e++) exp_s[e] = 4'b0;
    end else begin
`ifdef MORSE_KEY_DEBOUNCE_EN
      all_eq = 1'b1;
      for (int k = 2; k <= D + 1; k++) if (hist[k] != hist[2]) all_eq = 1'b0;
      nl = all_eq ? hist[2] : lvl_m;
`else
      nl = hist[1];
`endif
      if (nl && !lvl_m) begin
        t_r = cyc;
        for (int e = cyc + 1; e <= cyc + WG * CPU + 2; e++) exp_s[e] = 4'b0;
      end
      if (!nl && lvl_m) begin
        h = cyc - t_r;
        exp_s[cyc + 1] = (h / CPU >= DASH) ? 4'b0010 : 4'b0001;
        exp_s[cyc + 1 + CG * CPU] = 4'b0100;
        exp_s[cyc + 1 + WG * CPU] = 4'b1000;
      end
      lvl_m = nl;
    end
    obs = {word_space_inp, char_space_inp, dash_inp, dot_inp};
    chk("strobes", 32'(obs), 32'(exp_s[cyc]));
    chk("key_level", 32'(key_level), 32'(lvl_m));
    if (obs != 4'b0) begin
      chk("onehot", 32'($countones(obs)), 32'd1);
      chk("spacing", 32'(cyc - last_strobe >= CPU), 32'd1);
      last_strobe = cyc;
    end
    if (dot_inp) begin n_dot++; c_dot = cyc; end
    if (dash_inp) n_dash++;
    if (char_space_inp) begin n_char++; c_char = cyc; end
    if (word_space_inp) begin n_word++; c_word = cyc; end
    if (key_level) n_hi++;
  endtask
  task automatic hold(input logic v, input int n);
    key_in = v;
    repeat (n) step();
  endtask
  task automatic chk_all_zero(input string tag);
    chk(tag, 32'({dot_inp, dash_inp, char_space_inp, word_space_inp, key_level}), 32'd0);
  endtask
  initial begin
    for (int i = 0; i < MAXC; i++) exp_s[i] = 4'b0;
    clr_stats();
    repeat (3) step();
    chk_all_zero("reset_state");
    rst = 1'b1;
    // Single dot, then long idle.
    hold(1'b0, 5);
    clr_stats();
    hold(1'b1, 12);
    hold(1'b0, 600);
    chk("t1_dots", 32'(n_dot), 32'd1);
    chk("t1_dash", 32'(n_dash), 32'd0);
    chk("t1_char_ofs", 32'(c_char - c_dot), 32'(CG * CPU));
    chk("t1_word_ofs", 32'(c_word - c_dot), 32'(WG * CPU));
    chk("t1_chars", 32'(n_char), 32'd1);
    chk("t1_words", 32'(n_word), 32'd1);
    // Dash.
    clr_stats();
    hold(1'b1, 35);
    hold(1'b0, 100);
    chk("t2_dash", 32'(n_dash), 32'd1);
    chk("t2_dot", 32'(n_dot), 32'd0);
    // Intra-character gap: char space only after the second symbol.
    clr_stats();
    hold(1'b1, 12);
    hold(1'b0, 15);
    hold(1'b1, 12);
    hold(1'b0, 100);
    chk("t3_dots", 32'(n_dot), 32'd2);
    chk("t3_chars", 32'(n_char), 32'd1);
    chk("t3_char_after_2nd", 32'(c_char - c_dot), 32'(CG * CPU));
    // Inter-character gap: char space but no word space before the re-press.
    clr_stats();
    hold(1'b1, 12);
    hold(1'b0, 45);
    hold(1'b1, 12);
    hold(1'b0, 150);
    chk("t4_chars", 32'(n_char), 32'd2);
    chk("t4_words", 32'(n_word), 32'd1);
    // Re-press edge coinciding with the char threshold suppresses it; one cycle later does not.
    clr_stats();
    hold(1'b1, 12);
    hold(1'b0, 30);
    hold(1'b1, 12);
    hold(1'b0, 150);
    chk("t5_prio_chars", 32'(n_char), 32'd1);
    clr_stats();
    hold(1'b1, 12);
    hold(1'b0, 31);
    hold(1'b1, 12);
    hold(1'b0, 150);
    chk("t5_late_chars", 32'(n_char), 32'd2);
    // Short glitch.
    clr_stats();
    hold(1'b1, 2);
    hold(1'b0, 100);
`ifdef MORSE_KEY_DEBOUNCE_EN
    chk("t6_glitch_dots", 32'(n_dot), 32'd0);
    chk("t6_glitch_level", 32'(n_hi), 32'd0);
`else
    chk("t6_glitch_dots", 32'(n_dot), 32'd1);
    chk("t6_glitch_level", 32'(n_hi), 32'd2);
`endif
    // Reset mid-press, released during reset: nothing after reset.
    clr_stats();
    hold(1'b1, 30);
    rst = 1'b0;
    #1;
    chk_all_zero("t7_reset_now");
    hold(1'b1, 2);
    hold(1'b0, 5);
    rst = 1'b1;
    hold(1'b0, 100);
    chk("t7_dash", 32'(n_dash), 32'd0);
    chk("t7_dot", 32'(n_dot), 32'd0);
    // Key held through reset becomes a fresh press.
    clr_stats();
    hold(1'b1, 30);
    rst = 1'b0;
    #1;
    chk_all_zero("t8_reset_now");
    hold(1'b1, 5);
    rst = 1'b1;
    hold(1'b1, 15);
    hold(1'b0, 100);
    chk("t8_symbols", 32'(n_dot + n_dash), 32'd1);
    // Random keying checked cycle by cycle against the model.
    repeat (40) begin
      hold(1'b1, int'($urandom_range(45, 12)));
      hold(1'b0, int'($urandom_range(90, 12)));
    end
    hold(1'b0, 100);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
